// File: rtl/bcd_countdown_mmss.sv
// Presettable packed-BCD MM:SS countdown timer with load/start/pause control.
// Optional AUTO_RELOAD_EN: on expiry, reload the saved preset and keep running.
module bcd_countdown_mmss #(
    parameter int unsigned MIN_TENS_MAX = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    input  logic       start,
    input  logic       pause,
    output logic [7:0] min_out,
    output logic [7:0] sec_out,
    output logic       running,
    output logic       borrow_out,
    output logic       done
);

    localparam int unsigned DIGIT_W  = 4;
    localparam logic [DIGIT_W-1:0] MIN_TENS_LIM = DIGIT_W'(MIN_TENS_MAX);
    localparam logic [DIGIT_W-1:0] DIGIT_MAX    = DIGIT_W'(9);
    localparam logic [DIGIT_W-1:0] SEC_TENS_LIM = DIGIT_W'(5);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t     state;
`ifdef AUTO_RELOAD_EN
    logic [7:0] preset_min;
    logic [7:0] preset_sec;
`endif

    logic [7:0] clamp_min_c;
    logic [7:0] clamp_sec_c;
    logic [7:0] dec_min_c;
    logic [7:0] dec_sec_c;
    logic       dec_borrow_c;
    logic       dec_zero_c;
    logic       value_zero_c;

    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d,
                                                        input logic [DIGIT_W-1:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    // Per-digit clamp of the preset.
    always_comb begin
        clamp_min_c = {clamp_digit(load_min[7:4], MIN_TENS_LIM),
                       clamp_digit(load_min[3:0], DIGIT_MAX)};
        clamp_sec_c = {clamp_digit(load_sec[7:4], SEC_TENS_LIM),
                       clamp_digit(load_sec[3:0], DIGIT_MAX)};
    end

    // One-second BCD decrement with the seconds-to-minutes borrow.
    always_comb begin
        dec_min_c    = min_out;
        dec_sec_c    = sec_out;
        dec_borrow_c = 1'b0;
        if (sec_out[3:0] != '0) begin
            dec_sec_c[3:0] = sec_out[3:0] - DIGIT_W'(1);
        end else if (sec_out[7:4] != '0) begin
            dec_sec_c = {sec_out[7:4] - DIGIT_W'(1), DIGIT_MAX};
        end else if (min_out != '0) begin
            dec_sec_c    = {SEC_TENS_LIM, DIGIT_MAX};
            dec_borrow_c = 1'b1;
            if (min_out[3:0] != '0) begin
                dec_min_c[3:0] = min_out[3:0] - DIGIT_W'(1);
            end else begin
                dec_min_c = {min_out[7:4] - DIGIT_W'(1), DIGIT_MAX};
            end
        end
        dec_zero_c   = (dec_min_c == '0) && (dec_sec_c == '0);
        value_zero_c = (min_out == '0) && (sec_out == '0);
    end

    // Control FSM; borrow_out and done default low so they pulse for one cycle.
    always_ff @(posedge clk) begin
        borrow_out <= 1'b0;
        done       <= 1'b0;
        if (!reset) begin
            state      <= IDLE;
            min_out    <= '0;
            sec_out    <= '0;
            running    <= 1'b0;
`ifdef AUTO_RELOAD_EN
            preset_min <= '0;
            preset_sec <= '0;
`endif
        end else if (load && (state != RUN)) begin
            state      <= IDLE;
            min_out    <= clamp_min_c;
            sec_out    <= clamp_sec_c;
            running    <= 1'b0;
`ifdef AUTO_RELOAD_EN
            preset_min <= clamp_min_c;
            preset_sec <= clamp_sec_c;
`endif
        end else begin
            case (state)
                RUN: begin
                    if (pause) begin
                        state   <= PAUSED;
                        running <= 1'b0;
                    end else if (tick) begin
                        min_out    <= dec_min_c;
                        sec_out    <= dec_sec_c;
                        borrow_out <= dec_borrow_c;
                        if (dec_zero_c) begin
                            done <= 1'b1;
`ifdef AUTO_RELOAD_EN
                            if ((preset_min != '0) || (preset_sec != '0)) begin
                                min_out <= preset_min;
                                sec_out <= preset_sec;
                            end else begin
                                state   <= EXPIRED;
                                running <= 1'b0;
                            end
`else
                            state   <= EXPIRED;
                            running <= 1'b0;
`endif
                        end
                    end
                end
                IDLE, PAUSED: begin
                    if (start && !pause) begin
                        if (value_zero_c) begin
                            state <= EXPIRED;
                            done  <= 1'b1;
                        end else begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_countdown_mmss.sv
// Bench for bcd_countdown_mmss: directed scenarios plus random control traffic,
// checked against a model that tracks the time as a plain count of seconds.
module tb_bcd_countdown_mmss;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       load;
    logic [7:0] load_min;
    logic [7:0] load_sec;
    logic       start;
    logic       pause;
    logic [7:0] min_out;
    logic [7:0] sec_out;
    logic       running;
    logic       borrow_out;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    bcd_countdown_mmss dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .load       (load),
        .load_min   (load_min),
        .load_sec   (load_sec),
        .start      (start),
        .pause      (pause),
        .min_out    (min_out),
        .sec_out    (sec_out),
        .running    (running),
        .borrow_out (borrow_out),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Model: remaining time in seconds, mode 0=idle 1=run 2=paused 3=expired.
    int m_total  = 0;
    int m_preset = 0;
    int m_mode   = 0;
    bit m_borrow = 0;
    bit m_done   = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int lim(input int d, input int mx);
        return (d > mx) ? mx : d;
    endfunction

    function automatic int preset_secs(input logic [7:0] lm, input logic [7:0] ls);
        int mins, secs;
        mins = lim(int'(lm[7:4]), 9) * 10 + lim(int'(lm[3:0]), 9);
        secs = lim(int'(ls[7:4]), 5) * 10 + lim(int'(ls[3:0]), 9);
        return mins * 60 + secs;
    endfunction

    task automatic model_step();
        m_borrow = 0;
        m_done   = 0;
        if (!reset) begin
            m_total = 0; m_preset = 0; m_mode = 0;
        end else if (load && m_mode != 1) begin
            m_total  = preset_secs(load_min, load_sec);
            m_preset = m_total;
            m_mode   = 0;
        end else if (m_mode == 1) begin
            if (pause) begin
                m_mode = 2;
            end else if (tick) begin
                m_borrow = (m_total % 60 == 0);
                m_total  = m_total - 1;
                if (m_total == 0) begin
                    m_done = 1;
`ifdef AUTO_RELOAD_EN
                    if (m_preset != 0) m_total = m_preset;
                    else m_mode = 3;
`else
                    m_mode = 3;
`endif
                end
            end
        end else if ((m_mode == 0 || m_mode == 2) && start && !pause) begin
            if (m_total == 0) begin
                m_mode = 3;
                m_done = 1;
            end else begin
                m_mode = 1;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("min_out", min_out, to_bcd(m_total / 60));
        check("sec_out", sec_out, to_bcd(m_total % 60));
        check("running", 8'(running), 8'(m_mode == 1));
        check("borrow_out", 8'(borrow_out), 8'(m_borrow));
        check("done", 8'(done), 8'(m_done));
    endtask

    task automatic drive(input bit r, input bit l, input logic [7:0] lm, input logic [7:0] ls,
                         input bit s, input bit p, input bit t);
        reset = r; load = l; load_min = lm; load_sec = ls; start = s; pause = p; tick = t;
        cycle();
    endtask

    task automatic do_idle();                        drive(1, 0, 0, 0, 0, 0, 0); endtask
    task automatic do_load(input logic [7:0] m, input logic [7:0] s); drive(1, 1, m, s, 0, 0, 0); endtask
    task automatic do_start();                       drive(1, 0, 0, 0, 1, 0, 0); endtask
    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);

        // Reset mid-count
        do_load(8'h01, 8'h30); do_start(); do_ticks(5);
        drive(0, 0, 0, 0, 0, 0, 1);
        check("rst_min", min_out, 8'h00);
        check("rst_running", 8'(running), 8'h00);
        do_ticks(2);

        // Borrow boundary
        do_load(8'h02, 8'h00); do_start(); do_ticks(1);
        check("borrow_min", min_out, 8'h01);
        check("borrow_sec", sec_out, 8'h59);
        check("borrow_pulse", 8'(borrow_out), 8'h01);
        do_ticks(1);
        check("borrow_clear", 8'(borrow_out), 8'h00);
        drive(1, 0, 0, 0, 0, 1, 0);

        // BCD ones wrap
        do_load(8'h00, 8'h10); do_start(); do_ticks(1);
        check("wrap_sec", sec_out, 8'h09);
        drive(1, 0, 0, 0, 0, 1, 0);
        do_load(8'h10, 8'h00); do_start(); do_ticks(1);
        check("wrap_min", min_out, 8'h09);
        drive(1, 0, 0, 0, 0, 1, 0);

        // Expiry, then start/ticks after expiry, then start at 00:00
        do_load(8'h00, 8'h02); do_start(); do_ticks(2);
        do_ticks(2); do_start(); do_idle();
        do_load(8'h00, 8'h00); do_start(); do_idle(); do_start();

        // Pause beats tick; load ignored in RUN; start resumes
        do_load(8'h00, 8'h47); do_start(); do_ticks(2);
        drive(1, 0, 0, 0, 0, 1, 1);
        check("pause_sec", sec_out, 8'h45);
        do_ticks(2);
        do_start(); do_load(8'h05, 8'h05); do_ticks(1);
        check("load_in_run", sec_out, 8'h44);
        drive(1, 0, 0, 0, 0, 1, 0);

        // Clamp
        do_load(8'hAF, 8'h7C);
        check("clamp_min", min_out, 8'h99);
        check("clamp_sec", sec_out, 8'h59);

        // Auto-reload scenario (plain expiry when the feature is off)
        do_load(8'h00, 8'h03); do_start(); do_ticks(4);

        // Random control traffic
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] lm, ls;
            lm = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {4'd0, 4'($urandom_range(0, 1))};
            ls = ($urandom_range(0, 1) == 0) ? 8'($urandom) : {4'($urandom_range(0, 1)), 4'($urandom)};
            drive(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 39) == 0), lm, ls,
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 1) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_mmss.md
Name: bcd_countdown_mmss

Overview:
Presettable BCD minutes:seconds countdown timer. It counts down where the existing mod-60 BCD counter counts up. It consumes a one-cycle tick strobe, typically 1 Hz from the clock divider, and decrements a packed-BCD MM:SS value. It signals the seconds borrow and expiry to downstream display and alarm logic. Software or panel logic presets it with a load/start/pause handshake.

Parameters:
- MIN_TENS_MAX, default 9: upper clamp for the minutes tens digit on load (9 gives a 99:59 maximum).

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-low reset.
- tick, input, 1: count enable strobe, one clk cycle wide.
- load, input, 1: preset request.
- load_min, input, 8: packed-BCD minutes preset {tens, ones}.
- load_sec, input, 8: packed-BCD seconds preset {tens, ones}.
- start, input, 1: begin or resume counting.
- pause, input, 1: halt counting and hold the value.
- min_out, output, 8: packed-BCD current minutes.
- sec_out, output, 8: packed-BCD current seconds.
- running, output, 1: high while in RUN.
- borrow_out, output, 1: one-cycle pulse when seconds wrap from 00 to 59.
- done, output, 1: one-cycle pulse on expiry.

Behaviour:
- Reset (reset=0 at a clk edge): min_out=0x00, sec_out=0x00, running=0, borrow_out=0, done=0, state=IDLE, saved preset=00:00. Reset overrides every other input, including mid-count.
- States:
  - IDLE: after reset.
  - RUN: counting.
  - PAUSED: counting halted, value held.
  - EXPIRED: reached 00:00.
- All outputs are registered. An input sampled at edge N is reflected in the outputs after edge N.
- Load:
  - Accepted in IDLE, PAUSED and EXPIRED; ignored in RUN.
  - Sets min_out/sec_out and the saved preset; next state is IDLE.
  - Clamping per digit: min tens > MIN_TENS_MAX becomes MIN_TENS_MAX; min ones > 9 becomes 9; sec tens > 5 becomes 5; sec ones > 9 becomes 9. Example: load_sec=0x7C gives 0x59.
- Start:
  - From IDLE or PAUSED, the next state is RUN, or EXPIRED if the value is 00:00.
  - On the transition to EXPIRED, done pulses on the same edge that enters EXPIRED.
  - Ignored in RUN and EXPIRED.
- Priority in the same cycle: reset > load > pause > start > tick.
  - pause and tick together in RUN: go to PAUSED, no decrement.
- Decrement (RUN and tick=1):
  - sec ones 1..9: ones decrements.
  - sec ones 0 with sec tens > 0: ones becomes 9, tens decrements.
  - sec 00 with min != 00: sec becomes 0x59, minutes decrement by BCD rule (ones 0 gives 9 and tens-1), and borrow_out pulses.
  - A result of 00:00 goes to EXPIRED with done=1 for that one cycle. running drops on the same edge.
- tick is ignored outside RUN. borrow_out and done are 0 in every other cycle.
- EXPIRED holds 00:00 until load or reset.

Optional Feature:
- Macro AUTO_RELOAD_EN.
- When defined: on expiry, min_out/sec_out are reloaded with the saved preset on the same edge and the state stays RUN (running stays 1). done still pulses for one cycle. A saved preset of 00:00 is still treated as plain expiry.
- When undefined: expiry behaves as specified in Behaviour and holds EXPIRED at 00:00.

Test Plan:
- Reset mid-count: load 01:30, start, 5 ticks, assert reset=0 for one edge -> min_out=0x00, sec_out=0x00, running=0, done=0, state IDLE.
- Boundary borrow: load 02:00, start, 1 tick -> 01:59 and borrow_out=1 for exactly one cycle; next tick -> 01:58 with borrow_out=0.
- BCD ones wrap: load 00:10, start, 1 tick -> 00:09; load 10:00, start, 1 tick -> 09:59.
- Expiry: load 00:02, start, 2 ticks -> 00:00, done=1 for one cycle, running=0; further ticks and start leave 00:00 with no done. Separately, load 00:00 then start -> immediate EXPIRED with a single done pulse.
- Pause/priority: in RUN at 00:45, pause and tick in the same cycle -> 00:45 held, state PAUSED, running=0; load during RUN is ignored; start resumes from 00:45.
- Clamp and auto-reload:
  - Load min=0xAF, sec=0x7C -> 99:59.
  - With AUTO_RELOAD_EN defined: load 00:03, start, 3 ticks -> done pulse, value 00:03, running=1; 1 more tick -> 00:02.
